checker_fetch: RTL

Read-fetch engine that sits directly upstream of the checker core. It reads a contiguous region of target memory through a split request/completion read port and delivers it as an in-order 32-bit word stream that the checker's MPU consumes. It splits the transfer into bursts, never crosses a 4 KiB boundary, and is flow-controlled by free FIFO space. It reports completion or failure to the checker CSR logic.

---
 rtl/checker_fetch_if.sv | 32 +++
 rtl/checker_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/checker_fetch_if.sv
// Read request/completion port and output word stream of checker_fetch.
// master = fetch engine side; slave = memory completer and stream consumer side.
`timescale 1ns/1ps
interface checker_fetch_if;
   logic        rd_req_valid;
   logic        rd_req_ready;
   logic [63:0] rd_req_addr;
   logic [4:0]  rd_req_len;
   logic        rd_cpl_valid;
   logic [31:0] rd_cpl_data;
   logic        rd_cpl_last;
   logic        rd_cpl_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   modport master (
      output rd_req_valid, rd_req_addr, rd_req_len,
      input  rd_req_ready,
      input  rd_cpl_valid, rd_cpl_data, rd_cpl_last, rd_cpl_err,
      output out_valid, out_data,
      input  out_ready
   );

   modport slave (
      input  rd_req_valid, rd_req_addr, rd_req_len,
      output rd_req_ready,
      output rd_cpl_valid, rd_cpl_data, rd_cpl_last, rd_cpl_err,
      input  out_valid, out_data,
      output out_ready
   );
endinterface

// File: rtl/checker_fetch.sv
// Burst read-fetch engine: 4 KiB-safe bursts gated by output FIFO credit, in-order word stream.
// Optional completion timeout in WAIT is enabled by defining CHECKER_FETCH_TIMEOUT_EN.
`timescale 1ns/1ps
module checker_fetch #(
   parameter int BURST_WORDS    = 8,
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   input  logic            start,
   input  logic [63:0]     address,
   input  logic [15:0]     length,
   output logic            busy,
   output logic            done,
   output logic            error,
   checker_fetch_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_ERR} state_t;

   state_t        state_q, state_d;
   logic [61:0]   addr_q, addr_d;
   logic [15:0]   rem_q, rem_d;
   logic [4:0]    chunk_q, chunk_d;
   logic [4:0]    beat_cnt_q, beat_cnt_d;
   logic          req_vld_q, req_vld_d;
   logic [63:0]   req_addr_q, req_addr_d;
   logic [4:0]    req_len_q, req_len_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   mem_q [FIFO_DEPTH];

   logic          accept, req_hs, beat, beat_ok, final_ok, fail;
   logic          push, pop, drain_done, timeout_hit;
   logic [10:0]   limit;
   logic [16:0]   next_chunk;
   logic [CW-1:0] free_d;
   logic          unused_bits;

   assign unused_bits = ^{address[1:0], next_chunk[16:5]};

   // The done cycle is excluded so a start coincident with done is dropped.
   assign accept     = start && (state_q == S_IDLE || state_q == S_ERR) && !done_q;
   assign req_hs     = req_vld_q && bus.rd_req_ready;
   assign beat       = bus.rd_cpl_valid && (state_q == S_WAIT);
   assign beat_ok    = beat && !bus.rd_cpl_err && ((beat_cnt_q == 5'd1) == bus.rd_cpl_last);
   assign final_ok   = beat_ok && (beat_cnt_q == 5'd1);
   assign fail       = (beat && !beat_ok) || timeout_hit;
   assign push       = beat_ok;
   assign pop        = bus.out_valid && bus.out_ready;
   assign drain_done = (cnt_q == '0) || ((cnt_q == CW'(1)) && pop);

`ifdef CHECKER_FETCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;

   assign tmo_d       = (state_q == S_WAIT && !beat) ? tmo_q + TW'(1) : '0;
   assign timeout_hit = (state_q == S_WAIT) && !beat && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) tmo_q <= '0;
      else          tmo_q <= tmo_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      if (fail) begin
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_comb begin
      addr_d     = addr_q;
      rem_d      = rem_q;
      chunk_d    = chunk_q;
      beat_cnt_d = beat_cnt_q;
      if (accept) begin
         addr_d = address[63:2];
         rem_d  = length;
      end else if (final_ok) begin
         addr_d = addr_q + {57'd0, chunk_q};
         rem_d  = rem_q - {11'd0, chunk_q};
      end
      if (req_hs) begin
         chunk_d    = req_len_q;
         beat_cnt_d = req_len_q;
      end else if (beat_ok) begin
         beat_cnt_d = beat_cnt_q - 5'd1;
      end
   end

   // Size of the next burst, from the values the engine will hold next cycle.
   always_comb begin
      limit      = 11'd1024 - {1'b0, addr_d[9:0]};
      next_chunk = 17'(BURST_WORDS);
      if ({1'b0, rem_d} < next_chunk)  next_chunk = {1'b0, rem_d};
      if ({6'd0, limit} < next_chunk)  next_chunk = {6'd0, limit};
   end

   assign free_d = CW'(FIFO_DEPTH) - cnt_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_ERR: begin
            if (accept) state_d = (length == 16'd0) ? S_DRAIN : S_REQ;
            else        state_d = S_IDLE;
         end
         S_REQ:   if (req_hs) state_d = S_WAIT;
         S_WAIT: begin
            if (fail)          state_d = S_ERR;
            else if (final_ok) state_d = (rem_q == {11'd0, chunk_q}) ? S_DRAIN : S_REQ;
         end
         S_DRAIN: if (drain_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      done_d  = (state_q == S_DRAIN) && drain_done;
      error_d = error_q;
      if (accept)    error_d = 1'b0;
      else if (fail) error_d = 1'b1;
      // Credit check: only request when the whole burst fits in the FIFO.
      req_vld_d  = (state_d == S_REQ) && ({{(17-CW){1'b0}}, free_d} >= next_chunk);
      req_addr_d = {addr_d, 2'b00};
      req_len_d  = next_chunk[4:0];
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         chunk_q    <= '0;
         beat_cnt_q <= '0;
         req_vld_q  <= 1'b0;
         req_addr_q <= '0;
         req_len_q  <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         chunk_q    <= chunk_d;
         beat_cnt_q <= beat_cnt_d;
         req_vld_q  <= req_vld_d;
         req_addr_q <= req_addr_d;
         req_len_q  <= req_len_d;
         done_q     <= done_d;
         error_q    <= error_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.rd_cpl_data;
   end

   assign bus.rd_req_valid = req_vld_q;
   assign bus.rd_req_addr  = req_addr_q;
   assign bus.rd_req_len   = req_len_q;
   assign bus.out_valid    = (cnt_q != '0);
   assign bus.out_data     = bus.out_valid ? mem_q[rd_ptr_q] : 32'd0;
   assign busy             = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
   assign done             = done_q;
   assign error            = error_q;
endmodule
